// File: rtl/com_bus_pkg.sv
// Shared bus constants: queue sizing and processor ID encoding, used by the
// request queue and the arbiter.
package com_bus_pkg;

  localparam int BUF_WIDTH = 3;
  localparam int BUF_SIZE  = 1 << BUF_WIDTH;
  localparam int NUM_PROC  = 8;

  localparam logic [3:0] NO_PROC = 4'b0000;
  localparam logic [3:0] PROC1   = 4'b0001;
  localparam logic [3:0] PROC2   = 4'b0010;
  localparam logic [3:0] PROC3   = 4'b0011;
  localparam logic [3:0] PROC4   = 4'b0100;
  localparam logic [3:0] PROC5   = 4'b0101;
  localparam logic [3:0] PROC6   = 4'b0110;
  localparam logic [3:0] PROC7   = 4'b0111;
  localparam logic [3:0] PROC8   = 4'b1000;

  // Processor index 0..7 maps to bus ID 1..8; ID 0 means "nobody".
  function automatic logic [3:0] proc_id(input logic [2:0] idx);
    return {1'b0, idx} + 4'd1;
  endfunction

endpackage

// File: rtl/req_id_fifo.sv
// Circular buffer of processor IDs with first-word fall-through head.
// Push/pop qualifiers arrive already gated against full/empty.
module req_id_fifo
  import com_bus_pkg::*;
#(
  parameter int BUF_WIDTH = com_bus_pkg::BUF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [3:0]           push_id,
  input  logic                 pop,
  output logic [3:0]           head_id,
  output logic                 empty,
  output logic                 full,
  output logic [BUF_WIDTH:0]   count
);

  localparam int DEPTH = 1 << BUF_WIDTH;

  logic [3:0]           mem [DEPTH];
  logic [BUF_WIDTH-1:0] wr_ptr;
  logic [BUF_WIDTH-1:0] rd_ptr;
  logic [BUF_WIDTH:0]   count_r;

  // Pointers wrap naturally at their bit width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign empty   = (count_r == '0);
  assign full    = (count_r == (BUF_WIDTH+1)'(DEPTH));
  assign count   = count_r;
  assign head_id = empty ? NO_PROC : mem[rd_ptr];

endmodule

// File: rtl/com_bus_req_queue.sv
// Bus request queue: turns per-processor request rises into an ordered,
// duplicate-free queue of processor IDs. Define COM_BUS_REQ_RR_EN for
// round-robin candidate selection; default is fixed lowest-index priority.
module com_bus_req_queue
  import com_bus_pkg::*;
#(
  parameter int BUF_WIDTH = com_bus_pkg::BUF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         Com_Bus_Req_proc,
  input  logic               rd_en,
  output logic [3:0]         buf_out,
  output logic               buf_empty,
  output logic               buf_full,
  output logic [BUF_WIDTH:0] fifo_counter
);

  logic [7:0] req_q;
  logic [7:0] pending;
  logic [7:0] queued;
  logic       armed;
  logic [2:0] last_idx;

  logic [7:0] rise;
  logic [7:0] accepted;
  logic [7:0] cand;
  logic [2:0] sel_idx;
  logic       sel_valid;
  logic       do_push;
  logic       do_pop;
  logic [7:0] push_mask;
  logic [7:0] pop_mask;

  // The first edge after reset only samples the request levels, so a line
  // held high across reset must drop and rise again to be queued.
  assign rise     = armed ? (Com_Bus_Req_proc & ~req_q) : 8'h00;
  assign accepted = rise & ~pending & ~queued;
  assign cand     = (pending | accepted) & Com_Bus_Req_proc;
  assign do_pop   = rd_en & ~buf_empty;
  assign do_push  = sel_valid & (~buf_full | do_pop);

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 3'd0;
`ifdef COM_BUS_REQ_RR_EN
    for (int k = 1; k <= 8; k++) begin
      if (!sel_valid && cand[last_idx + 3'(k)]) begin
        sel_valid = 1'b1;
        sel_idx   = last_idx + 3'(k);
      end
    end
`else
    for (int k = 0; k < 8; k++) begin
      if (!sel_valid && cand[k]) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(k);
      end
    end
`endif
  end

  always_comb begin
    push_mask = 8'h00;
    pop_mask  = 8'h00;
    if (do_push) push_mask[sel_idx] = 1'b1;
    if (do_pop)  pop_mask[3'(buf_out - 4'd1)] = 1'b1;
  end

  // Withdrawn and just-enqueued candidates drop out of pending; the rest
  // (including everything blocked by a full queue) stay pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 8'h00;
      pending  <= 8'h00;
      queued   <= 8'h00;
      armed    <= 1'b0;
      last_idx <= 3'd0;
    end else begin
      req_q   <= Com_Bus_Req_proc;
      armed   <= 1'b1;
      pending <= cand & ~push_mask;
      queued  <= (queued & ~pop_mask) | push_mask;
      if (do_push) last_idx <= sel_idx;
    end
  end

  req_id_fifo #(
    .BUF_WIDTH (BUF_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (do_push),
    .push_id (proc_id(sel_idx)),
    .pop     (do_pop),
    .head_id (buf_out),
    .empty   (buf_empty),
    .full    (buf_full),
    .count   (fifo_counter)
  );

endmodule

// File: tb/tb_com_bus_req_queue.sv
// Self-checking bench for com_bus_req_queue: queue-based reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized traffic. Honours COM_BUS_REQ_RR_EN like the design.
module tb_com_bus_req_queue;

  localparam int BW   = 2;
  localparam int SIZE = 1 << BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    req = 8'h00;
  logic          rd_en = 1'b0;
  logic [3:0]    buf_out;
  logic          buf_empty;
  logic          buf_full;
  logic [BW:0]   fifo_counter;

  int n_cmp = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  com_bus_req_queue #(.BUF_WIDTH(BW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Com_Bus_Req_proc (req),
    .rd_en            (rd_en),
    .buf_out          (buf_out),
    .buf_empty        (buf_empty),
    .buf_full         (buf_full),
    .fifo_counter     (fifo_counter)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of IDs plus per-processor pending/queued sets.
  int       mq[$];
  bit [7:0] m_pend, m_qd, m_prev, m_cand;
  bit       m_armed;
  int       m_last, m_sel, m_id;
  bit       m_popping, m_pushing;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pend = '0; m_qd = '0; m_prev = '0; m_armed = 0; m_last = 0;
    end else begin
      m_cand = '0;
      for (int i = 0; i < 8; i++)
        if (req[i] && (m_pend[i] || (m_armed && !m_prev[i] && !m_qd[i])))
          m_cand[i] = 1;
      m_sel = -1;
`ifdef COM_BUS_REQ_RR_EN
      for (int k = 1; k <= 8; k++)
        if (m_sel < 0 && m_cand[(m_last + k) % 8]) m_sel = (m_last + k) % 8;
`else
      for (int i = 7; i >= 0; i--)
        if (m_cand[i]) m_sel = i;
`endif
      m_popping = rd_en && (mq.size() > 0);
      m_pushing = (m_sel >= 0) && (mq.size() < SIZE || m_popping);
      if (m_popping) begin
        m_id = mq.pop_front();
        m_qd[m_id-1] = 0;
      end
      m_pend = m_cand;
      if (m_pushing) begin
        mq.push_back(m_sel + 1);
        m_qd[m_sel] = 1;
        m_last = m_sel;
        m_pend[m_sel] = 0;
      end
      m_prev = req;
      m_armed = 1;
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Every falling edge: DUT outputs must match the model state.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model.buf_out", buf_out, (mq.size() > 0) ? mq[0] : 0);
      checkOutput("model.buf_empty", buf_empty, mq.size() == 0);
      checkOutput("model.buf_full", buf_full, mq.size() == SIZE);
      checkOutput("model.fifo_counter", fifo_counter, mq.size());
    end
  end

  task automatic applyStimulus(input logic [7:0] p, input logic r);
    req = p;
    rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b0);
  endtask

  logic [3:0] ord0, ord1, ord2;
  logic [7:0] p;
  logic       r;

  initial begin
`ifdef COM_BUS_REQ_RR_EN
    ord0 = 4'd7; ord1 = 4'd2; ord2 = 4'd6;
`else
    ord0 = 4'd2; ord1 = 4'd6; ord2 = 4'd7;
`endif
    #1 rst_n = 1'b0;
    check_en = 1'b1;
    #2;
    checkOutput("reset.buf_out", buf_out, 0);
    checkOutput("reset.buf_empty", buf_empty, 1);
    checkOutput("reset.buf_full", buf_full, 0);
    checkOutput("reset.fifo_counter", fifo_counter, 0);
    doReset();

    // Single rise on bit 2.
    applyStimulus(8'h04, 1'b0);
    checkOutput("rise2.buf_out", buf_out, 3);
    checkOutput("rise2.buf_empty", buf_empty, 0);
    checkOutput("rise2.fifo_counter", fifo_counter, 1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("pop.buf_empty", buf_empty, 1);

    // Make index 5 the last enqueued, then bits 5,1,6 rise together.
    applyStimulus(8'h20, 1'b0);
    checkOutput("rise5.buf_out", buf_out, 6);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h62, 1'b0);
    checkOutput("multi.first", buf_out, ord0);
    applyStimulus(8'h62, 1'b0);
    applyStimulus(8'h62, 1'b0);
    checkOutput("multi.count", fifo_counter, 3);
    applyStimulus(8'h00, 1'b1);
    checkOutput("multi.second", buf_out, ord1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("multi.third", buf_out, ord2);
    applyStimulus(8'h00, 1'b1);
    checkOutput("multi.drained", fifo_counter, 0);

    // Bit 3 withdrawn before it can be enqueued.
    applyStimulus(8'h09, 1'b0);
    checkOutput("withdraw.head", buf_out, 1);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkOutput("withdraw.count", fifo_counter, 1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("withdraw.empty", buf_empty, 1);

    // Bit 4 re-rises while its ID is still queued.
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h10, 1'b0);
    checkOutput("dedup.count", fifo_counter, 1);
    applyStimulus(8'h10, 1'b1);
    checkOutput("dedup.popped", fifo_counter, 0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h10, 1'b0);
    checkOutput("dedup.requeued", buf_out, 5);
    applyStimulus(8'h00, 1'b1);

    // Pop while empty, then reset with three entries.
    applyStimulus(8'h00, 1'b1);
    checkOutput("emptypop.buf_out", buf_out, 0);
    checkOutput("emptypop.count", fifo_counter, 0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h07, 1'b0);
    checkOutput("three.count", fifo_counter, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset.count", fifo_counter, 0);
    checkOutput("midreset.empty", buf_empty, 1);
    checkOutput("midreset.buf_out", buf_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'h07, 1'b0);
    applyStimulus(8'h07, 1'b0);
    checkOutput("heldhigh.count", fifo_counter, 0);
    applyStimulus(8'h00, 1'b0);

    // Fill, block while full, then pop and push on the same edge.
    for (int i = 0; i < SIZE; i++) applyStimulus(8'hFF, 1'b0);
    checkOutput("fill.full", buf_full, 1);
    checkOutput("fill.count", fifo_counter, SIZE);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("blocked.count", fifo_counter, SIZE);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("swap.count", fifo_counter, SIZE);
    checkOutput("swap.full", buf_full, 1);

    // Randomized traffic with alternating drain pressure and rare resets.
    p = 8'hFF;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 5) == 0) p[i] = ~p[i];
      r = ((n / 400) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        applyStimulus(p, r);
        rst_n = 1'b1;
      end
      applyStimulus(p, r);
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
